// File: rtl/ddmi_pkg.sv
// ddmi_pkg: shared widths for the DDMI poller result path.
package ddmi_pkg;
  localparam int DDMI_PC_W = 8;
  localparam int DDMI_RES_W = 9;
  localparam int DDMI_AW = 5;
endpackage

// File: rtl/ddmi_bank_ram.sv
// ddmi_bank_ram: simple dual-port RAM, one write port, one registered read port.
module ddmi_bank_ram #(
  parameter int AW = 6,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/ddmi_result_bank.sv
// ddmi_result_bank: double-buffered capture of poller results, swapped per sweep.
module ddmi_result_bank import ddmi_pkg::*; #(
  parameter int AW = DDMI_AW,
  parameter int STALE_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DDMI_PC_W-1:0]  pc,
  input  logic [DDMI_RES_W-1:0] result,
  input  logic                  strobe,
  input  logic                  hold,
  input  logic [AW-1:0]         host_addr,
  output logic [DDMI_RES_W-1:0] host_data,
  output logic                  host_valid,
  output logic [7:0]            sweep_count,
  output logic                  stale,
  output logic                  dropped
);
  logic wsel, seen, swap_pend, accept, boundary, swap, wsel_n;
  logic [AW-1:0] last_idx, idx;
  logic [2**AW-1:0] vld0, vld1, vld0_n, vld1_n;
  logic [STALE_W-1:0] stale_cnt;
  assign idx = pc[AW-1:0];
  assign accept = strobe && ((pc >> AW) == '0);
  assign boundary = accept && seen && (idx <= last_idx);
  assign swap = boundary && !hold;
  assign wsel_n = wsel ^ swap;
  assign stale = &stale_cnt;
  // the new write bank is cleared before this strobe's valid bit lands in it
  always_comb begin
    vld0_n = vld0;
    vld1_n = vld1;
    if (swap && wsel_n) vld1_n = '0;
    if (swap && !wsel_n) vld0_n = '0;
    if (accept && wsel_n) vld1_n[idx] = 1'b1;
    if (accept && !wsel_n) vld0_n[idx] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wsel <= 1'b0;
      seen <= 1'b0;
      swap_pend <= 1'b0;
      last_idx <= '0;
      vld0 <= '0;
      vld1 <= '0;
      sweep_count <= '0;
      stale_cnt <= '0;
      dropped <= 1'b0;
      host_valid <= 1'b0;
    end else begin
      wsel <= wsel_n;
      seen <= seen | accept;
      swap_pend <= swap ? 1'b0 : (swap_pend | boundary);
      last_idx <= accept ? idx : last_idx;
      vld0 <= vld0_n;
      vld1 <= vld1_n;
      sweep_count <= sweep_count + {7'd0, swap};
      stale_cnt <= strobe ? '0 : (stale ? stale_cnt : stale_cnt + 1'b1);
      dropped <= strobe && !accept;
      host_valid <= wsel_n ? vld0[host_addr] : vld1[host_addr];
    end
  ddmi_bank_ram #(.AW(AW + 1), .DW(DDMI_RES_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr ({wsel_n, idx}),
    .wdata (result),
    .raddr ({~wsel_n, host_addr}),
    .rdata (host_data)
  );
endmodule

// File: tb/tb_ddmi_result_bank.sv
// tb_ddmi_result_bank: randomized and directed checks against a sweep-level model.
module tb_ddmi_result_bank;
  localparam int AW = 5, STALE_W = 4, N = 1 << AW, SMAX = (1 << STALE_W) - 1;
  logic clk = 1'b0, rst, strobe, hold, host_valid, stale, dropped;
  logic [7:0] pc, sweep_count;
  logic [8:0] result, host_data;
  logic [AW-1:0] host_addr;
  int checks = 0, errors = 0;
  logic [8:0] m_cur [N], m_rd [N];
  bit m_cur_v [N], m_rd_v [N];
  bit m_seen, m_drop;
  int m_last, m_sweeps, m_idle;
  always #5 clk = ~clk;
  ddmi_result_bank #(.AW(AW), .STALE_W(STALE_W)) dut (
    .clk(clk), .rst(rst), .pc(pc), .result(result), .strobe(strobe), .hold(hold),
    .host_addr(host_addr), .host_data(host_data), .host_valid(host_valid),
    .sweep_count(sweep_count), .stale(stale), .dropped(dropped)
  );
  task automatic model_reset();
    foreach (m_cur_v[i]) begin m_cur_v[i] = 0; m_rd_v[i] = 0; end
    m_seen = 0; m_drop = 0; m_last = 0; m_sweeps = 0; m_idle = 0;
  endtask
  task automatic tick();
    m_drop = strobe && (pc >= N);
    if (strobe && pc < N) begin
      if (m_seen && int'(pc) <= m_last && !hold) begin
        m_rd = m_cur; m_rd_v = m_cur_v;
        foreach (m_cur_v[i]) m_cur_v[i] = 0;
        m_sweeps++;
      end
      m_cur[pc] = result; m_cur_v[pc] = 1; m_seen = 1; m_last = int'(pc);
    end
    m_idle = strobe ? 0 : (m_idle < SMAX ? m_idle + 1 : SMAX);
    @(posedge clk); #1;
  endtask
  task automatic put(input int p, input int r);
    strobe = 1; pc = 8'(p); result = 9'(r);
    tick();
    strobe = 0;
  endtask
  task automatic test_reset();
    rst = 1; strobe = 0; hold = 0; pc = 0; result = 0; host_addr = 0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({host_data, host_valid, sweep_count, stale, dropped} !== 20'd0) begin
      errors++; $display("FAIL reset_outputs got data=%0d valid=%0b sweeps=%0d stale=%0b dropped=%0b want all 0",
        host_data, host_valid, sweep_count, stale, dropped); end
    rst = 0;
  endtask
  task automatic test_sweep();
    for (int i = 0; i < 5; i++) put(i, 10 + i);
    put(0, 20);
    checks++; if (sweep_count !== 8'd1) begin errors++; $display("FAIL sweep_count got %0d want 1", sweep_count); end
    host_addr = 2; tick();
    checks++; if (host_data !== 9'd12 || host_valid !== 1'b1) begin errors++;
      $display("FAIL sweep_read2 got %0d/%0b want 12/1", host_data, host_valid); end
    host_addr = 7; tick();
    checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL sweep_read7 valid got %0b want 0", host_valid); end
    put(0, 33);
    host_addr = 0; tick();
    checks++; if (sweep_count !== 8'd2 || host_data !== 9'd20 || host_valid !== 1'b1) begin errors++;
      $display("FAIL sweep_newbank got sweeps=%0d data=%0d valid=%0b want 2/20/1", sweep_count, host_data, host_valid); end
  endtask
  task automatic test_drop();
    int sc;
    sc = int'(sweep_count);
    put(40, 99);
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse got %0b want 1", dropped); end
    tick();
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL drop_width got %0b want 0", dropped); end
    put(1, 7);
    checks++; if (int'(sweep_count) !== sc) begin errors++; $display("FAIL drop_last_idx sweeps got %0d want %0d", sweep_count, sc); end
    put(0, 8);
    host_addr = 8; tick();
    checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL drop_nowrite valid got %0b want 0", host_valid); end
    host_addr = 1; tick();
    checks++; if (host_valid !== 1'b1 || host_data !== 9'd7) begin errors++;
      $display("FAIL drop_entry1 got %0d/%0b want 7/1", host_data, host_valid); end
  endtask
  task automatic test_hold();
    int sc;
    logic [8:0] frozen, last2;
    host_addr = 1; tick();
    frozen = host_data; sc = int'(sweep_count);
    hold = 1;
    for (int s = 0; s < 3; s++)
      for (int i = 1; i < 4; i++) begin
        last2 = 9'($urandom_range(0, 511));
        put(i, int'(last2));
        checks++; if (int'(sweep_count) !== sc || host_data !== frozen) begin errors++;
          $display("FAIL hold_frozen got sweeps=%0d data=%0d want %0d/%0d", sweep_count, host_data, sc, frozen); end
      end
    hold = 0;
    put(1, 5);
    host_addr = 3; tick();
    checks++; if (int'(sweep_count) !== sc + 1 || host_data !== last2 || host_data !== m_rd[3]) begin errors++;
      $display("FAIL hold_release got sweeps=%0d data=%0d want %0d/%0d", sweep_count, host_data, sc + 1, last2); end
  endtask
  task automatic test_equal();
    int sc;
    put(0, 1);
    sc = int'(sweep_count);
    put(1, 2); put(2, 3); put(2, 44);
    checks++; if (int'(sweep_count) !== sc + 1) begin errors++; $display("FAIL equal_boundary got %0d want %0d", sweep_count, sc + 1); end
    put(2, 45);
    for (int a = 0; a < N; a++) begin
      host_addr = AW'(a); tick();
      checks++; if (host_valid !== (a == 2) || (a == 2 && host_data !== 9'd44)) begin errors++;
        $display("FAIL equal_only2 addr=%0d got %0d/%0b", a, host_data, host_valid); end
    end
  endtask
  task automatic test_stale();
    put(3, 3);
    for (int k = 1; k <= SMAX + 3; k++) begin
      tick();
      checks++; if (stale !== (k >= SMAX)) begin errors++; $display("FAIL stale_k%0d got %0b want %0b", k, stale, k >= SMAX); end
    end
    put(50, 0);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_clear got %0b want 0", stale); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      strobe = ($urandom_range(0, 1) == 1);
      pc = 8'($urandom_range(0, 39));
      result = 9'($urandom);
      hold = ($urandom_range(0, 5) == 0);
      host_addr = AW'($urandom);
      if ($urandom_range(0, 30) == 0) strobe = 0;
      tick();
      checks++; if (host_valid !== m_rd_v[host_addr] || (m_rd_v[host_addr] && host_data !== m_rd[host_addr])
          || int'(sweep_count) !== (m_sweeps & 255) || dropped !== m_drop || stale !== (m_idle == SMAX)) begin errors++;
        $display("FAIL random c=%0d data=%0d/%0d valid=%0b/%0b sweeps=%0d/%0d drop=%0b/%0b stale=%0b/%0b", c,
          host_data, m_rd[host_addr], host_valid, m_rd_v[host_addr], sweep_count, m_sweeps & 255, dropped, m_drop, stale, m_idle == SMAX); end
    end
    strobe = 0; hold = 0;
  endtask
  task automatic test_reset_mid();
    put(0, 1); put(1, 2); put(2, 3);
    rst = 1; #1;
    checks++; if ({host_data, host_valid, sweep_count, stale, dropped} !== 20'd0) begin
      errors++; $display("FAIL midreset_outputs got data=%0d valid=%0b sweeps=%0d", host_data, host_valid, sweep_count); end
    @(posedge clk); #1;
    rst = 0; model_reset();
    put(0, 9);
    host_addr = 0; tick();
    checks++; if (sweep_count !== 8'd0 || host_valid !== 1'b0) begin errors++;
      $display("FAIL midreset_noswap got sweeps=%0d valid=%0b want 0/0", sweep_count, host_valid); end
    put(0, 10);
    host_addr = 1; tick();
    checks++; if (sweep_count !== 8'd1 || host_valid !== 1'b0) begin errors++;
      $display("FAIL midreset_discard got sweeps=%0d valid=%0b want 1/0", sweep_count, host_valid); end
  endtask
  initial begin
    test_reset();
    test_sweep();
    test_drop();
    test_hold();
    test_equal();
    test_stale();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddmi_result_bank.md
# ddmi_result_bank

Capture stage directly downstream of the SFP DDMI I2C poller. It takes the poller's strobed result stream (program counter, 9-bit result, strobe) and files each result into a double-buffered register bank indexed by the low bits of the program counter. When a poll sweep completes, the bank swaps, so the host read port always sees one complete, self-consistent sweep. The block also reports a sweep counter and a stale-data flag for the monitoring/readback path.

## Interface
Parameters:
- `AW`, 5: index width; each bank has 2^AW entries.
- `STALE_W`, 24: width of the stale-data cycle counter.

Ports:
- `clk`, input, 1: single clock; shared with the poller.
- `rst`, input, 1: asynchronous, active-high reset.
- `pc`, input, 8: poller program counter for the current result.
- `result`, input, 9: poller result value.
- `strobe`, input, 1: one-cycle qualifier for `pc`/`result`.
- `hold`, input, 1: level input; the host freezes the read bank while it is high.
- `host_addr`, input, AW: read index.
- `host_data`, output, 9: registered read data from the read bank.
- `host_valid`, output, 1: registered; the addressed read-bank entry was written during its sweep.
- `sweep_count`, output, 8: number of bank swaps, wrapping 255→0.
- `stale`, output, 1: no strobe for 2^STALE_W−1 cycles.
- `dropped`, output, 1: one-cycle pulse when a strobe with `pc` ≥ 2^AW is ignored.

## Operation
- State: write-bank select `wsel`; read bank is `~wsel`. Also `last_idx[AW-1:0]`, `seen` (a strobe has been accepted since the last swap), per-bank valid vectors `vld0`/`vld1`, and `swap_pend`.
- Accepting a strobe: `idx = pc[AW-1:0]`. A strobe with `pc[7:AW] != 0` is ignored, pulses `dropped`, and does not update `last_idx`.
- Sweep boundary: an accepted strobe with `seen && idx <= last_idx` marks the end of the previous sweep.
  - If `hold`=0, swap in the same cycle: toggle `wsel`, clear the new write bank's valid vector, increment `sweep_count`, then write this strobe into the new write bank and set only its valid bit.
  - If `hold`=1, do not swap. Set `swap_pend` and keep writing into the current write bank, overwriting entries.
- Pending swap: when `swap_pend` is set and `hold` is low, the swap happens at the next sweep boundary, not on the falling edge of `hold`. The boundary swap clears `swap_pend`.
- On every accepted strobe: write `result` to `bank[wsel][idx]`, set the valid bit, set `last_idx = idx`, set `seen = 1`. A swap clears `seen` and the same strobe sets it again.
- Stale counter: cleared by any strobe, accepted or dropped. Otherwise it increments and saturates at all-ones. `stale` = counter at all-ones.

## Timing
- Reset values: `wsel`=0, `seen`=0, `swap_pend`=0, all valid bits 0, `sweep_count`=0, stale counter 0, `stale`=0, `dropped`=0, `host_data`=0, `host_valid`=0.
- Reset mid-sweep discards everything. The first strobe after reset never causes a swap.
- Write latency: an entry written at edge N is readable through the read bank only after a swap. Swap happens at the same edge as the boundary strobe.
- Read latency: `host_data`/`host_valid` update 1 cycle after `host_addr`, and reflect the bank selected after that edge's swap.
- Simultaneous `strobe` and a `hold` transition: `hold` is sampled at the same edge as the strobe.
- `stale` asserts exactly 2^STALE_W−1 cycles after the last strobe. It deasserts on the cycle after the next strobe.

## Structure
- Shared package `ddmi_pkg`:
  - `DDMI_PC_W`=8 and `DDMI_RES_W`=9 (match the poller outputs).
  - Default `AW`.
- One sub-module, `ddmi_bank_ram`: simple dual-port RAM of 2^(AW+1)×9 with one write port and one registered read port. Its address is {bank, idx}.
- Valid bits stay in flops in the top level so that a single-cycle clear is possible.

## Test plan
- Sweep pc 0..4 with results 10..14, then pc=0 with result 20 → `sweep_count`=1. Reading addr 2 gives 12 and valid=1. Reading addr 7 gives valid=0. The new write bank holds entry 0 = 20.
- Strobe pc=40 with `AW`=5 → `dropped` pulses for 1 cycle; no write occurs and `last_idx` is unchanged.
- `hold`=1 across two sweep boundaries → `sweep_count` is unchanged and the read data stays frozen. Release `hold`, run the next boundary → `sweep_count`+1, and the read bank holds the latest overwrites.
- Sweep 0,1,2, then 2 → boundary detected at the second 2 (equal index). The new bank has only entry 2 valid.
- `STALE_W`=4 with no strobes → `stale` asserts 15 cycles after the last strobe. A strobe clears it on the next cycle.
- Assert `rst` mid-sweep after pc 0..2 → all outputs return to 0. The post-reset strobe pc=0 causes no swap.
